// File: rtl/sync_fifo.sv
// Parametrised show-ahead synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int AF = D - 1,
    parameter int AE = 1,
    parameter int CW = $clog2(D) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          wr_full,
    output logic          almost_full,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_empty,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;

    generate
        if (W < 1) begin : g_bad_w
            $error("sync_fifo: W must be >= 1");
        end
        if (D < 2 || (D & (D - 1)) != 0) begin : g_bad_d
            $error("sync_fifo: D must be a power of two >= 2");
        end
        if (AF < 1 || AF > D) begin : g_bad_af
            $error("sync_fifo: AF must be in 1..D");
        end
        if (AE < 0 || AE > D - 1) begin : g_bad_ae
            $error("sync_fifo: AE must be in 0..D-1");
        end
        if (CW != PW) begin : g_bad_cw
            $error("sync_fifo: CW is derived and must not be overridden");
        end
    endgenerate

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] next_wr_ptr, next_rd_ptr;
    logic [CW-1:0] next_count;
    logic          writing, reading;
    logic          next_empty, next_full;

    assign writing = wr_en & ~wr_full;
    assign reading = rd_en & ~rd_empty;

    // Flags are registered from next-state pointers so they are exact one
    // cycle after the causing edge; clear forces both pointers home.
    always_comb begin
        next_wr_ptr = wr_ptr;
        next_rd_ptr = rd_ptr;
        if (clear) begin
            next_wr_ptr = '0;
            next_rd_ptr = '0;
        end else begin
            next_wr_ptr = wr_ptr + PW'(writing);
            next_rd_ptr = rd_ptr + PW'(reading);
        end
    end

    assign next_count = CW'(next_wr_ptr - next_rd_ptr);
    assign next_empty = (next_wr_ptr == next_rd_ptr);
    assign next_full  = (next_wr_ptr == {~next_rd_ptr[AW], next_rd_ptr[AW-1:0]});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_empty     <= 1'b1;
            wr_full      <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= next_wr_ptr;
            rd_ptr       <= next_rd_ptr;
            count        <= next_count;
            rd_empty     <= next_empty;
            wr_full      <= next_full;
            almost_empty <= (next_count <= CW'(AE));
            almost_full  <= (next_count >= CW'(AF));
            overflow     <= clear ? 1'b0 : (overflow  | (wr_en & wr_full));
            underflow    <= clear ? 1'b0 : (underflow | (rd_en & rd_empty));
        end
    end

    // Storage is deliberately not reset; a clear-cycle write is discarded.
    always_ff @(posedge clk) begin
        if (writing && !clear)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && wr_en && wr_full)
            $warning("sync_fifo: write request while full");
        if (reset_n && rd_en && rd_empty)
            $warning("sync_fifo: read request while empty");
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed sequences on a D=4 instance with a
// decoupled read monitor, plus a queue-model sweep on D=2/W=1 and D=16/W=32.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
    logic [2:0] count;

    logic        s_wr, s_rd;
    logic [31:0] s_data;
    logic        a_rd_data, a_full, a_af, a_empty, a_ae, a_ov, a_un;
    logic [1:0]  a_count;
    logic [31:0] b_rd_data;
    logic        b_full, b_af, b_empty, b_ae, b_ov, b_un;
    logic [4:0]  b_count;

    int tests = 0;
    int fails = 0;
    logic [7:0]  q[$];
    logic        qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    sync_fifo u_dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.W(1), .D(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .clear(1'b0),
        .wr_en(s_wr), .wr_data(s_data[0]), .wr_full(a_full), .almost_full(a_af),
        .rd_en(s_rd), .rd_data(a_rd_data), .rd_empty(a_empty), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ov), .underflow(a_un)
    );

    sync_fifo #(.W(32), .D(16)) u_d16 (
        .clk(clk), .reset_n(reset_n), .clear(1'b0),
        .wr_en(s_wr), .wr_data(s_data), .wr_full(b_full), .almost_full(b_af),
        .rd_en(s_rd), .rd_data(b_rd_data), .rd_empty(b_empty), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ov), .underflow(b_un)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a qualified read is visible mid-cycle; the head must match the scoreboard.
    always @(negedge clk) begin
        if (reset_n && rd_en && !rd_empty && !clear) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL monitor: unexpected read of %0h, scoreboard empty", rd_data);
            end else begin
                chk("monitor rd_data", {24'h0, rd_data}, {24'h0, q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        s_wr = 1'b0; s_rd = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_empty", rd_empty, 1);
        chk("reset wr_full", wr_full, 0);
        chk("reset count", count, 0);
        chk("reset almost_empty", almost_empty, 1);
        chk("reset almost_full", almost_full, 0);
        chk("reset overflow", overflow, 0);
        chk("reset underflow", underflow, 0);
        reset_n = 1'b1;

        // Reset mid-burst
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            q.push_back(8'(i));
            tick();
        end
        chk("burst count", count, 3);
        wr_data = 8'h04;
        #2 reset_n = 1'b0;
        #1;
        chk("async reset rd_empty", rd_empty, 1);
        chk("async reset wr_full", wr_full, 0);
        chk("async reset count", count, 0);
        chk("async reset almost_empty", almost_empty, 1);
        wr_en = 1'b0;
        q.delete();
        tick();
        reset_n = 1'b1;
        wr_en = 1'b1; wr_data = 8'h11; q.push_back(8'h11);
        tick();
        chk("post-reset rd_empty", rd_empty, 0);
        chk("post-reset rd_data", rd_data, 8'h11);
        chk("post-reset count", count, 1);
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post-reset drain empty", rd_empty, 1);

        // Fill
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            q.push_back(wr_data);
            tick();
            chk("fill count", count, 32'(i + 1));
            chk("fill almost_full", almost_full, (i + 1) >= 3);
            chk("fill wr_full", wr_full, (i + 1) == 4);
            chk("fill almost_empty", almost_empty, (i + 1) <= 1);
        end

        // Write+read at full: write dropped, read happens
        rd_en = 1'b1; wr_data = 8'hB0;
        tick();
        chk("full wr+rd count", count, 3);
        chk("full wr+rd overflow", overflow, 1);
        chk("full wr+rd wr_full", wr_full, 0);
        wr_data = 8'hB1; q.push_back(8'hB1);
        tick();
        chk("mid wr+rd count", count, 3);
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain count", count, 32'(2 - i));
            chk("drain almost_empty", almost_empty, (2 - i) <= 1);
            chk("drain almost_full", almost_full, 0);
        end
        rd_en = 1'b0;
        chk("drain rd_empty", rd_empty, 1);

        // Wrap-around at steady count 2
        wr_en = 1'b1;
        wr_data = 8'hE0; q.push_back(8'hE0); tick();
        wr_data = 8'hE1; q.push_back(8'hE1); tick();
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 8'(i); q.push_back(8'(i));
            tick();
            chk("wrap count", count, 2);
            chk("wrap wr_full", wr_full, 0);
            chk("wrap rd_empty", rd_empty, 0);
        end
        wr_en = 1'b0;
        tick(); tick();
        rd_en = 1'b0;
        chk("wrap drained", rd_empty, 1);

        // Underflow, then clear with a concurrent write
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("underflow set", underflow, 1);
        chk("underflow count", count, 0);
        chk("underflow rd_empty", rd_empty, 1);
        chk("overflow sticky", overflow, 1);
        wr_en = 1'b1;
        wr_data = 8'h55; q.push_back(8'h55); tick();
        wr_data = 8'h66; q.push_back(8'h66); tick();
        chk("pre-clear count", count, 2);
        clear = 1'b1; wr_data = 8'h77;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        q.delete();
        chk("clear count", count, 0);
        chk("clear rd_empty", rd_empty, 1);
        chk("clear underflow", underflow, 0);
        chk("clear overflow", overflow, 0);
        chk("clear wr_full", wr_full, 0);
        chk("clear almost_empty", almost_empty, 1);
        tick();
        chk("clear write discarded", rd_empty, 1);
        wr_en = 1'b1; wr_data = 8'h88; q.push_back(8'h88);
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("scoreboard drained", 32'(q.size()), 0);

        // Parameter sweep against reference queues
        begin
            bit ov_a = 0, un_a = 0, ov_b = 0, un_b = 0;
            for (int c = 0; c < 120; c++) begin
                bit wa, ra, wb, rb;
                if (c < 20)       begin s_wr = 1'b1; s_rd = 1'b0; end
                else if (c < 60)  begin s_wr = ($urandom_range(0, 3) != 0); s_rd = ($urandom_range(0, 3) == 0); end
                else if (c < 100) begin s_wr = ($urandom_range(0, 3) == 0); s_rd = ($urandom_range(0, 3) != 0); end
                else              begin s_wr = 1'b0; s_rd = 1'b1; end
                s_data = $urandom;
                if (qa.size() != 0) chk("d2 rd_data", a_rd_data, qa[0]);
                if (qb.size() != 0) chk("d16 rd_data", b_rd_data, qb[0]);
                wa = s_wr && qa.size() < 2;  ra = s_rd && qa.size() > 0;
                wb = s_wr && qb.size() < 16; rb = s_rd && qb.size() > 0;
                ov_a |= s_wr && qa.size() == 2;  un_a |= s_rd && qa.size() == 0;
                ov_b |= s_wr && qb.size() == 16; un_b |= s_rd && qb.size() == 0;
                if (ra) void'(qa.pop_front());
                if (wa) qa.push_back(s_data[0]);
                if (rb) void'(qb.pop_front());
                if (wb) qb.push_back(s_data);
                tick();
                chk("d2 count", a_count, 32'(qa.size()));
                chk("d2 rd_empty", a_empty, qa.size() == 0);
                chk("d2 wr_full", a_full, qa.size() == 2);
                chk("d2 almost_full", a_af, qa.size() >= 1);
                chk("d2 almost_empty", a_ae, qa.size() <= 1);
                chk("d16 count", b_count, 32'(qb.size()));
                chk("d16 rd_empty", b_empty, qb.size() == 0);
                chk("d16 wr_full", b_full, qb.size() == 16);
                chk("d16 almost_full", b_af, qb.size() >= 15);
                chk("d16 almost_empty", b_ae, qb.size() <= 1);
            end
            s_wr = 1'b0; s_rd = 1'b0;
            chk("d2 overflow", a_ov, ov_a);
            chk("d2 underflow", a_un, un_a);
            chk("d16 overflow", b_ov, ov_b);
            chk("d16 underflow", b_un, un_b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised synchronous FIFO; next generation of the team's 2-entry tiny FIFO. Generalised in data width and power-of-two depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Show-ahead (first-word-fall-through) read port; used as a general elastic buffer between AXI4 channel stages in the basal library.

Parameters:
- W, 8, data width in bits; must be >= 1.
- D, 4, depth in entries; power of two, >= 2.
- AF, D-1, almost_full threshold in entries; 1..D.
- AE, 1, almost_empty threshold in entries; 0..D-1.
- CW, $clog2(D)+1, count width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; empties FIFO, clears sticky errors.
- wr_en  input  1  write request.
- wr_data  input  W  write data.
- wr_full  output  1  registered full flag.
- almost_full  output  1  registered; count >= AF.
- rd_en  input  1  read request; pops the head entry.
- rd_data  output  W  head entry (show-ahead); valid when rd_empty=0.
- rd_empty  output  1  registered empty flag.
- almost_empty  output  1  registered; count <= AE.
- count  output  CW  registered occupancy, 0..D.
- overflow  output  1  sticky; set on wr_en while wr_full=1.
- underflow  output  1  sticky; set on rd_en while rd_empty=1.

Behaviour:
- One clock domain. reset_n is asynchronous active-low; assertion immediately forces all state; deassertion is used synchronously to clk.
- Reset values: rd_empty=1, wr_full=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0; pointers=0. Storage array is not reset.
- Qualified strobes: writing = wr_en & ~wr_full; reading = rd_en & ~rd_empty. Unqualified requests are ignored, but set the sticky errors.
- Pointers: wr_ptr and rd_ptr are each $clog2(D)+1 bits, with an extra wrap bit. Each increments by 1 on its strobe and wraps modulo 2*D.
- Storage is addressed by the low $clog2(D) bits of the pointers.
- Next-state values (next_wr_ptr, next_rd_ptr, next_count) are computed combinationally, including clear. All flags and count are registered from these next-state values, so every flag is exact in the cycle after the causing edge. There is no extra latency.
- Flag equations:
  - empty when next pointers are equal.
  - full when next pointers differ only in the wrap bit.
  - next_count = next_wr_ptr - next_rd_ptr, taken mod 2*D, CW bits.
  - almost_full = next_count >= AF; almost_empty = next_count <= AE.
- Write latency: data written at edge N is visible on rd_data and rd_empty=0 after edge N (1 cycle).
- Read: rd_data = mem[rd_ptr low bits], a combinational mux of registered storage. On a reading edge, rd_data advances to the next entry.
- Simultaneous write and read:
  - Not full, not empty: both occur; count is unchanged.
  - Full: only the read occurs, because the write is blocked by wr_full. The write is not accepted in the same cycle.
  - Empty: only the write occurs; no bypass to rd_data in the same cycle.
- clear=1 (synchronous): next pointers = 0, regardless of wr_en/rd_en in that cycle. After the edge: rd_empty=1, wr_full=0, count=0, overflow=0, underflow=0. clear has priority over the error-flag set.
- Sticky errors: overflow/underflow stay set until clear or reset.
- Reset mid-operation: all contents are discarded; state returns to the reset values immediately on reset_n=0.
- Simulation-only checks, excluded from synthesis: error message on wr_en&wr_full and on rd_en&rd_empty.
- Elaboration error if D is not a power of two or if AF/AE are out of range.

Test Plan:
- Reset (W=8, D=4): reset_n=0 mid-burst after 3 writes -> immediately rd_empty=1, wr_full=0, count=0, almost_empty=1; after release, a write of 0x11 gives rd_data=0x11 one cycle later.
- Fill/drain (D=4, AF=3, AE=1): write 0xA0..0xA3 on consecutive cycles -> count 1,2,3,4; almost_full rises with count=3; wr_full=1 after 4th edge. Read 4 -> rd_data 0xA0,0xA1,0xA2,0xA3 in order; rd_empty=1 after last edge; almost_empty=1 at count<=1.
- Full + simultaneous: at count=4 assert wr_en=rd_en with 0xB0 -> pops 0xA0, 0xB0 dropped, count=3, overflow=1. Next cycle wr+rd 0xB1 -> count stays 3.
- Wrap-around: 10 write/read pairs of 0x00..0x09 at count 2 steady state -> output order is preserved across pointer wrap; wr_full and rd_empty never assert.
- Underflow/clear: rd_en while empty -> underflow=1, count stays 0. Then write 2 entries and assert clear together with wr_en -> count=0, rd_empty=1, underflow=0, and the clear-cycle write is discarded.
- Parameter sweep: D=2, W=1 and D=16, W=32 -> fill to full and drain with a random sequence; flags and count match a reference queue model every cycle.
